// File: rtl/axi_rd_slice_pkg.sv
// Shared constants for the AXI4 read-path register slice: payload field positions,
// payload width functions and AXI burst/response encodings.
package axi_rd_slice_pkg;

  // AR payload {arid, araddr, arlen[7:0], arsize[2:0], arburst[1:0]} MSB..LSB
  localparam int AR_BURST_LSB = 0;
  localparam int AR_SIZE_LSB  = 2;
  localparam int AR_LEN_LSB   = 5;
  localparam int AR_ADDR_LSB  = 13;

  // R payload {rid, rdata, rresp[1:0], rlast} MSB..LSB
  localparam int R_LAST_BIT   = 0;
  localparam int R_RESP_LSB   = 1;
  localparam int R_DATA_LSB   = 3;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2,
    AXI_BURST_RSVD  = 2'd3
  } axi_burst_e;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'd0,
    AXI_RESP_EXOKAY = 2'd1,
    AXI_RESP_SLVERR = 2'd2,
    AXI_RESP_DECERR = 2'd3
  } axi_resp_e;

  function automatic int ar_pw(input int id_w, input int aw);
    return id_w + aw + 13;
  endfunction

  function automatic int r_pw(input int id_w, input int dw);
    return id_w + dw + 3;
  endfunction

endpackage

// File: rtl/axi_skid_buf.sv
// Two-entry skid buffer (main + skid register) with registered valid, data and ready;
// no combinational path from any input to any output.
module axi_skid_buf
  import axi_rd_slice_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_skid_valid;
  logic [W-1:0] r_skid_data;
  logic         r_in_ready;

  logic w_push;
  logic w_main_free;
  logic w_skid_load;
  logic w_skid_next;

  assign w_push      = in_valid && r_in_ready;
  assign w_main_free = !r_out_valid || out_ready;
  assign w_skid_load = w_push && !w_main_free;
  // Ready is low whenever skid holds data, so a push never coincides with a skid drain.
  assign w_skid_next = w_main_free ? 1'b0 : (r_skid_valid || w_push);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      if (w_main_free) begin
        if (r_skid_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_skid_data;
        end else begin
          r_out_valid <= w_push;
          if (w_push) r_out_data <= in_data;
        end
      end
      r_skid_valid <= w_skid_next;
      if (w_skid_load) r_skid_data <= in_data;
      r_in_ready   <= !w_skid_next;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: rtl/axi_rd_reg_slice.sv
// Full AXI4 read-path register slice (AR forward, R backward), one skid buffer per channel.
// Optional handshake statistics counters when AXI_RD_REG_SLICE_STATS_EN is defined.
module axi_rd_reg_slice
  import axi_rd_slice_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int ID_W = 10
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  input  logic [ar_pw(ID_W, AW)-1:0]   s_ar_pl,
  output logic                         m_arvalid,
  input  logic                         m_arready,
  output logic [ar_pw(ID_W, AW)-1:0]   m_ar_pl,
  input  logic                         m_rvalid,
  output logic                         m_rready,
  input  logic [r_pw(ID_W, DW)-1:0]    m_r_pl,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic [r_pw(ID_W, DW)-1:0]    s_r_pl
`ifdef AXI_RD_REG_SLICE_STATS_EN
  ,
  output logic [31:0]                  ar_hs_cnt,
  output logic [31:0]                  r_burst_cnt
`endif
);

  localparam int AR_PW = ar_pw(ID_W, AW);
  localparam int R_PW  = r_pw(ID_W, DW);

  axi_skid_buf #(.W(AR_PW)) u_ar_buf (
    .clk       (aclk),
    .rst_n     (aresetn),
    .in_valid  (s_arvalid),
    .in_ready  (s_arready),
    .in_data   (s_ar_pl),
    .out_valid (m_arvalid),
    .out_ready (m_arready),
    .out_data  (m_ar_pl)
  );

  axi_skid_buf #(.W(R_PW)) u_r_buf (
    .clk       (aclk),
    .rst_n     (aresetn),
    .in_valid  (m_rvalid),
    .in_ready  (m_rready),
    .in_data   (m_r_pl),
    .out_valid (s_rvalid),
    .out_ready (s_rready),
    .out_data  (s_r_pl)
  );

`ifdef AXI_RD_REG_SLICE_STATS_EN
  logic [31:0] r_ar_hs_cnt;
  logic [31:0] r_r_burst_cnt;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ar_hs_cnt   <= '0;
      r_r_burst_cnt <= '0;
    end else begin
      if (m_arvalid && m_arready) r_ar_hs_cnt <= r_ar_hs_cnt + 32'd1;
      if (s_rvalid && s_rready && s_r_pl[R_LAST_BIT]) r_r_burst_cnt <= r_r_burst_cnt + 32'd1;
    end
  end

  assign ar_hs_cnt   = r_ar_hs_cnt;
  assign r_burst_cnt = r_r_burst_cnt;
`endif

endmodule
